// File: rtl/encode_instruction.sv
// Packs decoded RV64I fields into 32-bit instruction words on a valid/ready stream.
// Range-checks immediates and expands LI into ADDI or LUI(+ADDIW).
module encode_instruction #(
    parameter int IMMEDIATE_WIDTH = 32,
    parameter int TYPE_WIDTH      = 3,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TYPE_WIDTH-1:0]      fmt,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 funct3,
    input  logic [6:0]                 funct7,
    input  logic [4:0]                 rd_number,
    input  logic [4:0]                 rs1_number,
    input  logic [4:0]                 rs2_number,
    input  logic [IMMEDIATE_WIDTH-1:0] imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic                       out_last,
    output logic                       out_err,
    output logic [ERR_CNT_WIDTH-1:0]   err_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {S_IDLE, S_LI2} state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_out_valid;
    logic [31:0]                r_out_inst;
    logic                       r_out_last;
    logic                       r_out_err;
    logic [ERR_CNT_WIDTH-1:0]   r_err_count;
    logic [31:0]                r_pend_inst;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_out_hs;
    logic                       w_fits12;
    logic                       w_fits13;
    logic                       w_fits21;
    logic                       w_shift;
    logic [11:0]                w_li_lo;
    logic [19:0]                w_li_hi;
    logic [31:0]                w_word;
    logic [31:0]                w_addiw;
    logic                       w_err;
    logic                       w_last;
    logic                       w_two;

    assign w_fits12 = (imm[IMMEDIATE_WIDTH-1:11] == {(IMMEDIATE_WIDTH-11){imm[11]}});
    assign w_fits13 = (imm[IMMEDIATE_WIDTH-1:12] == {(IMMEDIATE_WIDTH-12){imm[12]}});
    assign w_fits21 = (imm[IMMEDIATE_WIDTH-1:20] == {(IMMEDIATE_WIDTH-20){imm[20]}});
    assign w_shift  = ((opcode == 7'b0010011) || (opcode == 7'b0011011)) &&
                      ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Adding 0x800 before taking bits [31:12] only carries in imm[11].
    assign w_li_lo  = imm[11:0];
    assign w_li_hi  = imm[31:12] + {19'd0, imm[11]};
    assign w_addiw  = {w_li_lo, rd_number, 3'b000, rd_number, 7'b0011011};

    always_comb begin
        w_word = '0;
        w_err  = 1'b0;
        w_last = 1'b1;
        w_two  = 1'b0;
        case (fmt)
            TYPE_WIDTH'(0): w_word = {funct7, rs2_number, rs1_number, funct3, rd_number, opcode};
            TYPE_WIDTH'(1): begin
                if (w_shift) begin
                    w_err  = (imm[IMMEDIATE_WIDTH-1:6] != '0);
                    w_word = {funct7[6:1], imm[5:0], rs1_number, funct3, rd_number, opcode};
                end else begin
                    w_err  = !w_fits12;
                    w_word = {imm[11:0], rs1_number, funct3, rd_number, opcode};
                end
            end
            TYPE_WIDTH'(2): begin
                w_err  = !w_fits12;
                w_word = {imm[11:5], rs2_number, rs1_number, funct3, imm[4:0], opcode};
            end
            TYPE_WIDTH'(3): begin
                w_err  = !w_fits13 || imm[0];
                w_word = {imm[12], imm[10:5], rs2_number, rs1_number, funct3,
                          imm[4:1], imm[11], opcode};
            end
            TYPE_WIDTH'(4): begin
                w_err  = (imm[11:0] != '0);
                w_word = {imm[31:12], rd_number, opcode};
            end
            TYPE_WIDTH'(5): begin
                w_err  = !w_fits21 || imm[0];
                w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd_number, opcode};
            end
            TYPE_WIDTH'(6): begin
                if (w_fits12) begin
                    w_word = {imm[11:0], 5'd0, 3'b000, rd_number, 7'b0010011};
                end else begin
                    w_word = {w_li_hi, rd_number, 7'b0110111};
                    w_two  = (w_li_lo != '0);
                    w_last = !w_two;
                end
            end
            default: w_err = 1'b1;
        endcase
        if (w_err) begin
            w_word = NOP;
            w_last = 1'b1;
            w_two  = 1'b0;
        end
    end

    always_comb begin
        w_in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
        w_accept     = in_valid && w_in_ready;
        w_out_hs     = r_out_valid && out_ready;
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_two) w_state_next = S_LI2;
            S_LI2:   if (w_out_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
            r_err_count <= '0;
            r_pend_inst <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= w_word;
            r_out_last  <= w_last;
            r_out_err   <= w_err;
            if (w_two) r_pend_inst <= w_addiw;
            if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
        end else if ((r_state == S_LI2) && w_out_hs) begin
            r_out_inst <= r_pend_inst;
            r_out_last <= 1'b1;
            r_out_err  <= 1'b0;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_last  = r_out_last;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule
